// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: mm:ss BCD stopwatch with start/stop/clear control and seven-segment decode
module stopwatch_bcd #(
  parameter bit HOLD_AT_MAX    = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic ss_q, press, at_max, inc, roll, c0, c1, c2, running_n, wrap_n;
  assign press  = start_stop & ~ss_q;
  assign at_max = {min_tens, min_ones, sec_tens, sec_ones} == 16'h5959;
  assign inc    = (state == RUN) & tick & ~clear;
  assign roll   = inc & ~(HOLD_AT_MAX & at_max);
  assign c0     = sec_ones == 4'd9;
  assign c1     = c0 & (sec_tens == 4'd5);
  assign c2     = c1 & (min_ones == 4'd9);
  // Edge register resets high so a button held through reset never starts the count
  always_ff @(posedge clk)
    if (reset) ss_q <= 1'b1;
    else ss_q <= start_stop;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (clear) state_n = IDLE;
    else
      unique case (state)
        IDLE:  state_n = press ? RUN : IDLE;
        RUN:   state_n = press ? PAUSE : (HOLD_AT_MAX && tick && at_max) ? DONE : RUN;
        PAUSE: state_n = press ? RUN : PAUSE;
        DONE:  state_n = DONE;
      endcase
  end
  always_comb begin
    running_n = state_n == RUN;
    wrap_n    = inc & at_max & !HOLD_AT_MAX;
  end
  always_ff @(posedge clk)
    if (reset) begin
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      running <= running_n;
      wrap    <= wrap_n;
    end
  // Pure BCD cascade: each digit rolls only when every lower digit is at its maximum
  always_ff @(posedge clk)
    if (reset || clear) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (roll) begin
      sec_ones <= c0 ? 4'd0 : sec_ones + 4'd1;
      if (c0) sec_tens <= c1 ? 4'd0 : sec_tens + 4'd1;
      if (c1) min_ones <= c2 ? 4'd0 : min_ones + 4'd1;
      if (c2) min_tens <= (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
    end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction
  assign hex0 = seg7(sec_ones);
  assign hex1 = seg7(sec_tens);
  assign hex2 = seg7(min_ones);
  assign hex3 = seg7(min_tens);
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed checks of counting, pause, wrap/hold, clear and reset behaviour
module tb_stopwatch_bcd;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic a_run, a_wrap, b_run, b_wrap;
  logic [6:0] a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  stopwatch_bcd #(.HOLD_AT_MAX(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
    .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
    .running(a_run), .wrap(a_wrap), .hex0(a_h0), .hex1(a_h1), .hex2(a_h2), .hex3(a_h3));
  stopwatch_bcd #(.HOLD_AT_MAX(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
    .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
    .running(b_run), .wrap(b_wrap), .hex0(b_h0), .hex1(b_h1), .hex2(b_h2), .hex3(b_h3));
  wire [15:0] a_t = {a_mt, a_mo, a_st, a_so};
  wire [15:0] b_t = {b_mt, b_mo, b_st, b_so};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press();
    start_stop = 1'b1; cyc();
    start_stop = 1'b0; cyc();
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask
  task automatic do_clear();
    clear = 1'b1; cyc();
    clear = 1'b0; cyc();
  endtask
  initial begin
    cyc(2);
    chk("rst_digits", a_t, 16'h0000);
    chk("rst_run", a_run, 0);
    chk("rst_wrap", a_wrap, 0);
    chk("rst_hex", {a_h3, a_h2, a_h1, a_h0}, {4{7'b1000000}});
    reset = 1'b0; cyc();
    // Test 1: start and count ten seconds
    press();
    chk("t1_run", a_run, 1);
    ticks(10);
    chk("t1_digits", a_t, 16'h0010);
    chk("t1_digits_b", b_t, 16'h0010);
    chk("t1_hex1", a_h1, 7'b1111001);
    chk("t1_hex0", a_h0, 7'b1000000);
    chk("t1_run2", a_run, 1);
    // Test 2: pause/resume and coincident press+tick
    do_clear();
    chk("t2_clr_run", a_run, 0);
    press(); ticks(5);
    chk("t2_at5", a_t, 16'h0005);
    press();
    chk("t2_paused", a_run, 0);
    ticks(3);
    chk("t2_hold5", a_t, 16'h0005);
    start_stop = 1'b1; tick = 1'b1; cyc();
    start_stop = 1'b0; tick = 1'b0; cyc();
    chk("t2_resume_noinc", a_t, 16'h0005);
    chk("t2_resume_run", a_run, 1);
    ticks(1);
    chk("t2_at6", a_t, 16'h0006);
    start_stop = 1'b1; tick = 1'b1; cyc();
    start_stop = 1'b0; tick = 1'b0; cyc();
    chk("t2_run_press_tick", a_t, 16'h0007);
    chk("t2_run_press_pause", a_run, 0);
    // Test 3/4: wrap on the free-running instance, hold on the other
    do_clear(); press();
    ticks(59);
    chk("t3_0059", a_t, 16'h0059);
    ticks(1);
    chk("t3_0100", a_t, 16'h0100);
    ticks(3538);
    chk("t3_5958", a_t, 16'h5958);
    chk("t3_5958_b", b_t, 16'h5958);
    ticks(1);
    chk("t3_5959", a_t, 16'h5959);
    chk("t3_hex3_b", b_h3, 7'b0010010);
    chk("t3_hex2_b", b_h2, 7'b0010000);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("t3_wrap_digits", a_t, 16'h0000);
    chk("t3_wrap_hi", a_wrap, 1);
    chk("t3_wrap_run", a_run, 1);
    chk("t4_hold_digits", b_t, 16'h5959);
    chk("t4_done_run", b_run, 0);
    chk("t4_no_wrap", b_wrap, 0);
    cyc();
    chk("t3_wrap_lo", a_wrap, 0);
    press();
    chk("t4_press_ignored", b_run, 0);
    ticks(2);
    chk("t4_still_5959", b_t, 16'h5959);
    chk("t3_paused_a", a_t, 16'h0000);
    do_clear();
    chk("t4_clear", b_t, 16'h0000);
    press();
    chk("t4_idle_press", b_run, 1);
    // Test 5: clear beats press and tick at 12:34
    do_clear(); press();
    ticks(754);
    chk("t5_1234", a_t, 16'h1234);
    clear = 1'b1; tick = 1'b1; start_stop = 1'b1; cyc();
    clear = 1'b0; tick = 1'b0; start_stop = 1'b0;
    chk("t5_clear_digits", a_t, 16'h0000);
    chk("t5_clear_run", a_run, 0);
    cyc();
    press();
    chk("t5_idle_to_run", a_run, 1);
    // Test 6: button held through reset, then reset mid-count
    reset = 1'b1; start_stop = 1'b1; cyc(2);
    reset = 1'b0; cyc(2);
    chk("t6_held_nostart", a_run, 0);
    start_stop = 1'b0; cyc();
    chk("t6_release", a_run, 0);
    press();
    chk("t6_start", a_run, 1);
    ticks(197);
    chk("t6_0317", a_t, 16'h0317);
    reset = 1'b1; cyc();
    chk("t6_rst_digits", a_t, 16'h0000);
    chk("t6_rst_run", a_run, 0);
    chk("t6_rst_wrap", a_wrap, 0);
    chk("t6_rst_hex", {a_h3, a_h2, a_h1, a_h0}, {4{7'b1000000}});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
